// File: rtl/dir_dram_bridge_pkg.sv
// Shared types for the Data_Dir <-> DRAM AXI4-Lite bridge: entry layout,
// DRAM word type, bridge FSM states and address constants.
package dir_dram_bridge_pkg;

  localparam int unsigned ADDR_W = 17;
  localparam logic [ADDR_W-1:0] DRAM_BASE = 17'h10000;
  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef logic [63:0] dram_word_t;

  // Packed Data_Dir entry, 57 bits, fields in the same order as the DRAM word
  typedef struct packed {
    logic [11:0] index_a;
    logic [11:0] index_b;
    logic [3:0]  month;
    logic [11:0] index_c;
    logic [11:0] index_d;
    logic [4:0]  day;
  } data_dir_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW,
    ST_W,
    ST_B,
    ST_RSP
  } bridge_state_t;

endpackage

// File: rtl/dir_dram_bridge_if.sv
// AXI4-Lite bus between the bridge (master) and the DRAM controller (slave).
interface dir_dram_bridge_if #(
  parameter int unsigned ADDR_W = 17
);
  logic              AR_VALID;
  logic [ADDR_W-1:0] AR_ADDR;
  logic              AR_READY;
  logic              R_VALID;
  logic [63:0]       R_DATA;
  logic [1:0]        R_RESP;
  logic              R_READY;
  logic              AW_VALID;
  logic [ADDR_W-1:0] AW_ADDR;
  logic              AW_READY;
  logic              W_VALID;
  logic [63:0]       W_DATA;
  logic              W_READY;
  logic              B_VALID;
  logic [1:0]        B_RESP;
  logic              B_READY;

  modport master (
    output AR_VALID, AR_ADDR, R_READY, AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY,
    input  AR_READY, R_VALID, R_DATA, R_RESP, AW_READY, W_READY, B_VALID, B_RESP
  );

  modport slave (
    input  AR_VALID, AR_ADDR, R_READY, AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY,
    output AR_READY, R_VALID, R_DATA, R_RESP, AW_READY, W_READY, B_VALID, B_RESP
  );
endinterface

// File: rtl/dir_word_conv.sv
// Combinational packing of a Data_Dir entry into a DRAM word and back.
// Month/Day are zero-extended on write and truncated on read.
module dir_word_conv
  import dir_dram_bridge_pkg::*;
(
  input  data_dir_t  dir_i,
  output dram_word_t word_o,
  input  dram_word_t word_i,
  output data_dir_t  dir_o
);

  logic unused_bits;

  assign word_o = {dir_i.index_a, dir_i.index_b, 4'h0, dir_i.month,
                   dir_i.index_c, dir_i.index_d, 3'h0, dir_i.day};

  assign dir_o = '{index_a: word_i[63:52],
                   index_b: word_i[51:40],
                   month:   word_i[35:32],
                   index_c: word_i[31:20],
                   index_d: word_i[19:8],
                   day:     word_i[4:0]};

  // Upper bits of the Month and Day bytes carry no information for Data_Dir
  assign unused_bits = ^{word_i[39:36], word_i[7:5]};

endmodule

// File: rtl/dir_dram_bridge.sv
// AXI4-Lite master turning single Data_Dir read/write requests into one DRAM
// word transaction each; address and data phases are strictly serialized.
module dir_dram_bridge #(
  parameter int unsigned ADDR_W = dir_dram_bridge_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] DRAM_BASE = dir_dram_bridge_pkg::DRAM_BASE
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  input  logic         req_write,
  input  logic [7:0]   req_no,
  input  logic [56:0]  req_wdata,
  output logic         busy,
  output logic         rsp_valid,
  output logic [56:0]  rsp_rdata,
  output logic         rsp_err,
  dir_dram_bridge_if.master axi
);
  import dir_dram_bridge_pkg::*;

  bridge_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  data_dir_t         wdata_q, wdata_d;
  data_dir_t         rdata_q, rdata_d;
  logic              err_q, err_d;

  dram_word_t        w_word;
  data_dir_t         r_dir;

  logic ar_valid, r_ready, aw_valid, w_valid, b_ready, rsp_pulse;

  dir_word_conv u_conv (
    .dir_i  (wdata_q),
    .word_o (w_word),
    .word_i (axi.R_DATA),
    .dir_o  (r_dir)
  );

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    ar_valid  = 1'b0;
    r_ready   = 1'b0;
    aw_valid  = 1'b0;
    w_valid   = 1'b0;
    b_ready   = 1'b0;
    rsp_pulse = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = DRAM_BASE + ADDR_W'({req_no, 3'b000});
          wdata_d = data_dir_t'(req_wdata);
          err_d   = 1'b0;
          state_d = req_write ? ST_AW : ST_AR;
        end
      end
      ST_AR: begin
        ar_valid = 1'b1;
        if (axi.AR_READY) state_d = ST_R;
      end
      ST_R: begin
        r_ready = 1'b1;
        if (axi.R_VALID) begin
          rdata_d = r_dir;
          err_d   = (axi.R_RESP != RESP_OKAY);
          state_d = ST_RSP;
        end
      end
      ST_AW: begin
        aw_valid = 1'b1;
        if (axi.AW_READY) state_d = ST_W;
      end
      ST_W: begin
        w_valid = 1'b1;
        if (axi.W_READY) state_d = ST_B;
      end
      ST_B: begin
        b_ready = 1'b1;
        if (axi.B_VALID) begin
          err_d   = (axi.B_RESP != RESP_OKAY);
          state_d = ST_RSP;
        end
      end
      ST_RSP: begin
        rsp_pulse = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign axi.AR_VALID = ar_valid;
  assign axi.AR_ADDR  = addr_q;
  assign axi.R_READY  = r_ready;
  assign axi.AW_VALID = aw_valid;
  assign axi.AW_ADDR  = addr_q;
  assign axi.W_VALID  = w_valid;
  assign axi.W_DATA   = w_word;
  assign axi.B_READY  = b_ready;

  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = rsp_pulse;
  assign rsp_rdata = rdata_q;
  // Error flag is only meaningful alongside the completion pulse
  assign rsp_err   = rsp_pulse & err_q;

endmodule
